// File: rtl/uc_pkg.sv
// uc_pkg: shared opcode encodings, ALU-field slice positions and FSM state type
// for the uc_stack control unit.
package uc_pkg;

  // Opcode encodings
  localparam logic [5:0] OP_NOP       = 6'b000000;
  localparam logic [5:0] OP_JUMP      = 6'b000001;
  localparam logic [5:0] OP_JZ        = 6'b000010;
  localparam logic [5:0] OP_JNZ       = 6'b000011;
  // LIMM is a pattern: 0001xx
  localparam logic [5:0] OP_LIMM_MASK = 6'b111100;
  localparam logic [5:0] OP_LIMM_VAL  = 6'b000100;
  localparam logic [5:0] OP_CALL      = 6'b001000;
  localparam logic [5:0] OP_RET       = 6'b001001;
  localparam logic [5:0] OP_HALT      = 6'b001111;

  // Any opcode with this bit set is an ALU instruction
  localparam int OP_ALU_BIT = 5;

  // ALU operation field inside the opcode
  localparam int ALU_MSB = 4;
  localparam int ALU_LSB = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } uc_state_e;

endpackage

// File: rtl/uc_ret_stack.sv
// uc_ret_stack: DEPTH x PCW LIFO holding return addresses.
// A push while full and a pop while empty are ignored here; the caller
// decides whether such attempts are errors. top reads 0 when empty.
module uc_ret_stack #(
  parameter int PCW   = 10,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic           full,
  output logic           empty,
  output logic [PCW-1:0] top
);

  // sp spans 0..DEPTH, so it needs one more code than the entry index
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  logic [PCW-1:0] r_mem [DEPTH];
  logic [SPW-1:0] r_sp;
  logic [IW-1:0]  w_wr_idx;
  logic [IW-1:0]  w_top_idx;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_wr_idx  = r_sp[IW-1:0];
  assign w_top_idx = w_wr_idx - IW'(1);

  assign full  = (r_sp == SPW'(DEPTH));
  assign empty = (r_sp == '0);
  assign top   = empty ? '0 : r_mem[w_top_idx];

  assign w_do_push = push & ~full & ~reset;
  assign w_do_pop  = pop & ~empty & ~reset;

  // Stack pointer: cleared by reset, moves by one per push or pop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= '0;
    end else if (w_do_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  // Entry storage: contents are don't-care after reset, so no reset term
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/uc_stack.sv
// uc_stack: opcode decoder for the datapath with RUN/HALT FSM, pipeline
// enable and (optionally) a return-address stack for CALL/RET.
// Build option: define UC_RET_STACK_EN to include the return stack; without
// it CALL and RET decode as NOP, s_ret/ret_addr/stk_err are constant 0.
// The FSM state is visible to the outside world through `halted`.
module uc_stack
  import uc_pkg::*;
#(
  parameter int PCW   = 10,
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [5:0]     opcode,
  input  logic           z,
  input  logic [PCW-1:0] pc_plus1,
  output logic           pc_we,
  output logic           s_inc,
  output logic           s_ret,
  output logic           s_inm,
  output logic           we3,
  output logic           wez,
  output logic [2:0]     op_alu,
  output logic [PCW-1:0] ret_addr,
  output logic           halted,
  output logic           stk_err
);

  uc_state_e r_state;
  uc_state_e w_state_nxt;
  logic      r_stk_err;
  logic      w_stk_err_nxt;

`ifdef UC_RET_STACK_EN
  logic           w_push;
  logic           w_pop;
  logic           w_full;
  logic           w_empty;
  logic [PCW-1:0] w_top;

  uc_ret_stack #(
    .PCW   (PCW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (pc_plus1),
    .full  (w_full),
    .empty (w_empty),
    .top   (w_top)
  );

  assign ret_addr = reset ? '0 : w_top;
`else
  // Without the stack the return address input and depth have no consumer
  logic w_unused;
  assign w_unused = ^{pc_plus1, 32'(DEPTH)};
  assign ret_addr = '0;
`endif

  assign op_alu  = opcode[ALU_MSB:ALU_LSB];
  assign halted  = (r_state == ST_HALT) & ~reset;
  assign stk_err = r_stk_err & ~reset;

  // State and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_stk_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_stk_err <= w_stk_err_nxt;
    end
  end

  // Decode: mux selects follow the opcode, write strobes and stack/FSM
  // activity are qualified by en; reset and HALT force a NOP
  always_comb begin
    pc_we         = 1'b0;
    s_inc         = 1'b1;
    s_ret         = 1'b0;
    s_inm         = 1'b0;
    we3           = 1'b0;
    wez           = 1'b0;
    w_state_nxt   = r_state;
    w_stk_err_nxt = r_stk_err;
`ifdef UC_RET_STACK_EN
    w_push        = 1'b0;
    w_pop         = 1'b0;
`endif
    if (!reset && r_state == ST_RUN) begin
      pc_we = en;
      if (opcode[OP_ALU_BIT]) begin
        we3 = en;
        wez = en;
      end else if ((opcode & OP_LIMM_MASK) == OP_LIMM_VAL) begin
        s_inm = 1'b1;
        we3   = en;
      end else begin
        case (opcode)
          OP_NOP:  ;
          OP_JUMP: s_inc = 1'b0;
          OP_JZ:   s_inc = ~z;
          OP_JNZ:  s_inc = z;
          OP_HALT: if (en) w_state_nxt = ST_HALT;
`ifdef UC_RET_STACK_EN
          OP_CALL: begin
            // The jump is taken even when the push has no room
            s_inc = 1'b0;
            if (en) begin
              if (w_full) w_stk_err_nxt = 1'b1;
              else        w_push        = 1'b1;
            end
          end
          OP_RET: begin
            // Returning from an empty stack falls through as a NOP
            if (!w_empty) begin
              s_ret = 1'b1;
              s_inc = 1'b0;
              w_pop = en;
            end else if (en) begin
              w_stk_err_nxt = 1'b1;
            end
          end
`else
          OP_CALL, OP_RET: ;
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uc_stack.sv
// tb_uc_stack: directed and random stimulus for uc_stack, checked against a
// behavioural model (queue-based return stack, rule-based decode).
module tb_uc_stack;

  localparam int PCW   = 10;
  localparam int DEPTH = 8;
`ifdef UC_RET_STACK_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           en;
  logic [5:0]     opcode;
  logic           z;
  logic [PCW-1:0] pc_plus1;
  logic           pc_we;
  logic           s_inc;
  logic           s_ret;
  logic           s_inm;
  logic           we3;
  logic           wez;
  logic [2:0]     op_alu;
  logic [PCW-1:0] ret_addr;
  logic           halted;
  logic           stk_err;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state
  logic [PCW-1:0] m_stk[$];
  bit             m_halted;
  bit             m_err;

  uc_stack #(.PCW(PCW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .opcode   (opcode),
    .z        (z),
    .pc_plus1 (pc_plus1),
    .pc_we    (pc_we),
    .s_inc    (s_inc),
    .s_ret    (s_ret),
    .s_inm    (s_inm),
    .we3      (we3),
    .wez      (wez),
    .op_alu   (op_alu),
    .ret_addr (ret_addr),
    .halted   (halted),
    .stk_err  (stk_err)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset for one edge with an arbitrary opcode applied; outputs must read as NOP
  task automatic do_reset(input logic [5:0] op);
    reset    = 1'b1;
    en       = 1'b1;
    opcode   = op;
    z        = 1'b0;
    pc_plus1 = PCW'(10'h3FF);
    @(negedge clk);
    chk("rst.pc_we",    pc_we,    0);
    chk("rst.s_inc",    s_inc,    1);
    chk("rst.s_ret",    s_ret,    0);
    chk("rst.s_inm",    s_inm,    0);
    chk("rst.we3",      we3,      0);
    chk("rst.wez",      wez,      0);
    chk("rst.op_alu",   op_alu,   (op >> 2) & 7);
    chk("rst.ret_addr", ret_addr, 0);
    chk("rst.halted",   halted,   0);
    chk("rst.stk_err",  stk_err,  0);
    @(posedge clk);
    #1;
    m_stk.delete();
    m_halted = 0;
    m_err    = 0;
    reset    = 1'b0;
    @(negedge clk);
    chk("post_rst.halted",   halted,   0);
    chk("post_rst.stk_err",  stk_err,  0);
    chk("post_rst.ret_addr", ret_addr, 0);
    @(posedge clk);
    #1;
  endtask

  // One instruction cycle: drive, compare against the model, then advance the model
  task automatic do_cycle(input logic [5:0] op, input logic zz, input logic [PCW-1:0] pc,
                          input logic e, input string tag);
    bit x_inc, x_ret, x_inm, x_we3, x_wez, x_pcwe;
    bit do_push, do_pop, go_halt, set_err;
    int x_ra;
    x_inc = 1; x_ret = 0; x_inm = 0; x_we3 = 0; x_wez = 0; x_pcwe = 0;
    do_push = 0; do_pop = 0; go_halt = 0; set_err = 0;
    opcode   = op;
    z        = zz;
    pc_plus1 = pc;
    en       = e;
    x_ra = (m_stk.size() == 0) ? 0 : int'(m_stk[$]);
    if (!m_halted) begin
      x_pcwe = e;
      if (op >= 32) begin
        x_we3 = e; x_wez = e;
      end else if (op >= 4 && op <= 7) begin
        x_inm = 1; x_we3 = e;
      end else if (op == 1) begin
        x_inc = 0;
      end else if (op == 2) begin
        x_inc = !zz;
      end else if (op == 3) begin
        x_inc = zz;
      end else if (op == 15) begin
        go_halt = e;
      end else if (op == 8 && STK_EN) begin
        x_inc = 0;
        if (e) begin
          if (m_stk.size() == DEPTH) set_err = 1;
          else                       do_push = 1;
        end
      end else if (op == 9 && STK_EN) begin
        if (m_stk.size() > 0) begin
          x_ret = 1; x_inc = 0; do_pop = e;
        end else begin
          set_err = e;
        end
      end
    end
    @(negedge clk);
    chk({tag, ".pc_we"},    pc_we,    x_pcwe);
    chk({tag, ".s_inc"},    s_inc,    x_inc);
    chk({tag, ".s_ret"},    s_ret,    x_ret);
    chk({tag, ".s_inm"},    s_inm,    x_inm);
    chk({tag, ".we3"},      we3,      x_we3);
    chk({tag, ".wez"},      wez,      x_wez);
    chk({tag, ".op_alu"},   op_alu,   (op >> 2) & 7);
    chk({tag, ".ret_addr"}, ret_addr, x_ra);
    chk({tag, ".halted"},   halted,   m_halted);
    chk({tag, ".stk_err"},  stk_err,  m_err);
    @(posedge clk);
    #1;
    if (do_push) m_stk.push_back(pc);
    if (do_pop)  void'(m_stk.pop_back());
    if (set_err) m_err = 1;
    if (go_halt) m_halted = 1;
  endtask

  initial begin
    int r;
    logic [5:0] rop;
    reset = 1'b1; en = 1'b0; opcode = '0; z = 1'b0; pc_plus1 = '0;

    // Reset state
    do_reset(6'b101100);

    // ALU, conditional jumps
    do_cycle(6'b101100, 1'b0, 10'h001, 1'b1, "alu");
    chk("alu.op_alu_lit", op_alu, 3'b011);
    do_cycle(6'b000010, 1'b1, 10'h002, 1'b1, "jz_z1");
    do_cycle(6'b000011, 1'b1, 10'h003, 1'b1, "jnz_z1");
    do_cycle(6'b000010, 1'b0, 10'h004, 1'b1, "jz_z0");
    do_cycle(6'b000101, 1'b0, 10'h005, 1'b1, "limm");
    do_cycle(6'b000001, 1'b0, 10'h006, 1'b1, "jump");
    do_cycle(6'b011010, 1'b0, 10'h007, 1'b1, "undef");

    // Nested CALL/RET
    do_cycle(6'b001000, 1'b0, 10'h05A, 1'b1, "call1");
    do_cycle(6'b001000, 1'b0, 10'h100, 1'b1, "call2");
    do_cycle(6'b001001, 1'b0, 10'h000, 1'b1, "ret1");
    do_cycle(6'b001001, 1'b0, 10'h000, 1'b1, "ret2");
    do_cycle(6'b000000, 1'b0, 10'h000, 1'b1, "after_ret");

    // Overflow then drain, with one underflow
    do_reset(6'b001000);
    for (int i = 0; i < DEPTH + 1; i++)
      do_cycle(6'b001000, 1'b0, PCW'(10'h010 + i), 1'b1, $sformatf("fill%0d", i));
    for (int i = 0; i < DEPTH + 1; i++)
      do_cycle(6'b001001, 1'b0, 10'h000, 1'b1, $sformatf("drain%0d", i));
    do_cycle(6'b000000, 1'b0, 10'h000, 1'b1, "err_sticky");

    // Stall during CALL, then the same CALL enabled
    do_reset(6'b000000);
    do_cycle(6'b001000, 1'b0, 10'h2A5, 1'b0, "stall_call");
    do_cycle(6'b001000, 1'b0, 10'h2A5, 1'b0, "stall_call2");
    do_cycle(6'b001000, 1'b0, 10'h2A5, 1'b1, "en_call");
    do_cycle(6'b001001, 1'b0, 10'h000, 1'b0, "stall_ret");
    do_cycle(6'b001001, 1'b0, 10'h000, 1'b1, "en_ret");
    do_cycle(6'b001001, 1'b0, 10'h000, 1'b1, "under_ret");

    // HALT, blocked activity, reset out of HALT
    do_cycle(6'b001111, 1'b0, 10'h000, 1'b0, "halt_stalled");
    do_cycle(6'b001000, 1'b0, 10'h123, 1'b1, "call_pre_halt");
    do_cycle(6'b001111, 1'b0, 10'h000, 1'b1, "halt");
    do_cycle(6'b000110, 1'b0, 10'h000, 1'b1, "limm_halted");
    do_cycle(6'b001001, 1'b0, 10'h000, 1'b1, "ret_halted");
    do_cycle(6'b111111, 1'b1, 10'h000, 1'b1, "alu_halted");
    do_reset(6'b001001);

    // Random stimulus
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) do_reset(6'($urandom_range(0, 63)));
      r = $urandom_range(0, 19);
      if (r <= 2)       rop = 6'($urandom_range(32, 63));
      else if (r == 3)  rop = 6'd0;
      else if (r == 4)  rop = 6'd1;
      else if (r == 5)  rop = 6'd2;
      else if (r == 6)  rop = 6'd3;
      else if (r <= 8)  rop = 6'($urandom_range(4, 7));
      else if (r <= 12) rop = 6'd8;
      else if (r <= 16) rop = 6'd9;
      else if (r == 17) rop = 6'($urandom_range(0, 31));
      else if (r == 18) rop = 6'($urandom_range(10, 14));
      else              rop = 6'd15;
      do_cycle(rop, 1'($urandom_range(0, 1)), PCW'($urandom_range(0, 1023)),
               1'($urandom_range(0, 4) != 0), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
